// File: rtl/program_loader.sv
// Boot-stream program loader: header word count, little-endian payload words written to imem,
// core held in reset until the load completes. Optional trailing checksum check: define CHECKSUM_EN.
module program_loader #(
   parameter int          MAX_WORDS    = 256,
   parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
   input  logic        i_clk,
   input  logic        i_arstn,
   input  logic        i_byteValid,
   input  logic [7:0]  i_byte,
   output logic        o_byteReady,
   input  logic        i_reload,
   output logic        o_imemWriteEn,
   output logic [31:0] o_imemWriteAddress,
   output logic [31:0] o_imemWriteData,
   output logic        o_coreSrst,
   output logic        o_loadDone,
   output logic        o_error
);

   typedef enum logic [2:0] {
      S_HEADER  = 3'd0,
      S_PAYLOAD = 3'd1,
`ifdef CHECKSUM_EN
      S_CHECK   = 3'd2,
`endif
      S_DONE    = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic        r_live;
   logic [1:0]  r_byteCnt;
   logic [23:0] r_shift;
   logic [31:0] r_wordCount;
   logic [31:0] r_index;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_data;
`ifdef CHECKSUM_EN
   logic [31:0] r_sum;
`endif

   logic        w_active;
   logic        w_ready;
   logic        w_accept;
   logic        w_lastByte;
   logic        w_lastWord;
   logic [31:0] w_word;

   // Completed field: earlier bytes sit in the low lanes, the current byte lands in [31:24].
   assign w_word     = {i_byte, r_shift};
   assign w_accept   = i_byteValid & w_ready;
   assign w_lastByte = w_accept & (r_byteCnt == 2'd3);
   assign w_lastWord = (r_index == r_wordCount - 32'd1);

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         r_state <= S_HEADER;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_active    = 1'b0;
      o_coreSrst  = 1'b1;
      o_loadDone  = 1'b0;
      o_error     = 1'b0;
      case (r_state)
         S_HEADER:  w_active = 1'b1;
         S_PAYLOAD: w_active = 1'b1;
`ifdef CHECKSUM_EN
         S_CHECK:   w_active = 1'b1;
`endif
         S_DONE: begin
            o_coreSrst = 1'b0;
            o_loadDone = 1'b1;
         end
         S_ERROR:   o_error = 1'b1;
         default:   w_active = 1'b0;
      endcase
      // r_live keeps ready low until the first edge after reset release.
      w_ready = r_live & w_active & ~i_reload;

      if (i_reload) begin
         w_stateNext = S_HEADER;
      end else if (w_lastByte) begin
         case (r_state)
            S_HEADER: begin
               if (w_word == 32'd0)
                  w_stateNext = S_DONE;
               else if (w_word > 32'(MAX_WORDS))
                  w_stateNext = S_ERROR;
               else
                  w_stateNext = S_PAYLOAD;
            end
            S_PAYLOAD: begin
               if (w_lastWord) begin
`ifdef CHECKSUM_EN
                  w_stateNext = S_CHECK;
`else
                  w_stateNext = S_DONE;
`endif
               end
            end
`ifdef CHECKSUM_EN
            S_CHECK: w_stateNext = (w_word == r_sum) ? S_DONE : S_ERROR;
`endif
            default: w_stateNext = r_state;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         r_live      <= 1'b0;
         r_byteCnt   <= 2'd0;
         r_shift     <= 24'd0;
         r_wordCount <= 32'd0;
         r_index     <= 32'd0;
         r_we        <= 1'b0;
         r_addr      <= 32'd0;
         r_data      <= 32'd0;
`ifdef CHECKSUM_EN
         r_sum       <= 32'd0;
`endif
      end else begin
         r_live <= 1'b1;
         r_we   <= 1'b0;
         if (i_reload) begin
            r_byteCnt <= 2'd0;
            r_shift   <= 24'd0;
            r_index   <= 32'd0;
`ifdef CHECKSUM_EN
            r_sum     <= 32'd0;
`endif
         end else if (w_accept) begin
            r_byteCnt <= r_byteCnt + 2'd1;
            r_shift   <= w_word[31:8];
            if (w_lastByte) begin
               case (r_state)
                  S_HEADER: r_wordCount <= w_word;
                  S_PAYLOAD: begin
                     r_we    <= 1'b1;
                     r_addr  <= BASE_ADDRESS + {r_index[29:0], 2'b00};
                     r_data  <= w_word;
                     r_index <= r_index + 32'd1;
`ifdef CHECKSUM_EN
                     r_sum   <= r_sum + w_word;
`endif
                  end
                  default: r_index <= r_index;
               endcase
            end
         end
      end
   end

   // A reload arriving while a write is pending kills the strobe.
   assign o_byteReady        = w_ready;
   assign o_imemWriteEn      = r_we & ~i_reload;
   assign o_imemWriteAddress = r_addr;
   assign o_imemWriteData    = r_data;

endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader; expected imem writes are queued before the stream is sent.
module tb_program_loader;

   logic        i_clk = 1'b0;
   logic        i_arstn = 1'b0;
   logic        i_byteValid = 1'b0;
   logic [7:0]  i_byte = 8'h00;
   logic        i_reload = 1'b0;
   logic        o_byteReady;
   logic        o_imemWriteEn;
   logic [31:0] o_imemWriteAddress;
   logic [31:0] o_imemWriteData;
   logic        o_coreSrst;
   logic        o_loadDone;
   logic        o_error;

   program_loader #(.MAX_WORDS(256), .BASE_ADDRESS(32'h0)) dut (
      .i_clk(i_clk), .i_arstn(i_arstn), .i_byteValid(i_byteValid), .i_byte(i_byte),
      .o_byteReady(o_byteReady), .i_reload(i_reload), .o_imemWriteEn(o_imemWriteEn),
      .o_imemWriteAddress(o_imemWriteAddress), .o_imemWriteData(o_imemWriteData),
      .o_coreSrst(o_coreSrst), .o_loadDone(o_loadDone), .o_error(o_error)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      string        name;
      logic [159:0] s;
      int           n;
      int           nw;
      logic [31:0]  a0, d0, a1, d1;
      logic         done;
      logic         err;
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[6];
   int   nv;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   gaps = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [159:0] s, input int n, input int nw,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic done, input logic err);
      vec_t v;
      v.name = name; v.s = s; v.n = n; v.nw = nw;
      v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
      v.done = done; v.err = err;
      return v;
   endfunction

   // Scoreboard: every write strobe must match the head of the expectation queue.
   always @(negedge i_clk) begin
      wr_t e;
      if (o_imemWriteEn) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_write: addr %h data %h with none expected",
                     o_imemWriteAddress, o_imemWriteData);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", o_imemWriteAddress, e.a);
            chk("wr_data", o_imemWriteData, e.d);
            $display("write addr=%h data=%h", o_imemWriteAddress, o_imemWriteData);
         end
      end
   end

   // Caller is at posedge+1; the byte is accepted at the next rising edge.
   task automatic send_byte(input logic [7:0] b);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge i_clk);
            #1;
         end
      end
      i_byteValid = 1'b1;
      i_byte = b;
      #1;
      chk("ready", {31'd0, o_byteReady}, 32'd1);
      @(posedge i_clk);
      #1;
      i_byteValid = 1'b0;
      i_byte = 8'($urandom);
   endtask

   // Stream bytes 0..cnt-1 of a total-byte stream whose first byte is the most significant.
   task automatic send_stream(input logic [159:0] s, input int total, input int cnt);
      for (int i = 0; i < cnt; i++) send_byte(s[8*(total-1-i) +: 8]);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic pulse_reload(input logic with_byte);
      i_reload = 1'b1;
      i_byteValid = with_byte;
      i_byte = 8'hAA;
      #1;
      chk("ready_during_reload", {31'd0, o_byteReady}, 32'd0);
      @(posedge i_clk);
      #1;
      i_reload = 1'b0;
      i_byteValid = 1'b0;
      chk("srst_after_reload", {31'd0, o_coreSrst}, 32'd1);
      chk("done_after_reload", {31'd0, o_loadDone}, 32'd0);
      chk("err_after_reload", {31'd0, o_error}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, {31'd0, o_byteReady}, 32'd0);
      chk({tag, "_we"}, {31'd0, o_imemWriteEn}, 32'd0);
      chk({tag, "_addr"}, o_imemWriteAddress, 32'd0);
      chk({tag, "_data"}, o_imemWriteData, 32'd0);
      chk({tag, "_srst"}, {31'd0, o_coreSrst}, 32'd1);
      chk({tag, "_done"}, {31'd0, o_loadDone}, 32'd0);
      chk({tag, "_err"}, {31'd0, o_error}, 32'd0);
   endtask

   task automatic check_end(input string tag, input logic done, input logic err);
      chk({tag, "_done"}, {31'd0, o_loadDone}, {31'd0, done});
      chk({tag, "_err"}, {31'd0, o_error}, {31'd0, err});
      chk({tag, "_srst"}, {31'd0, o_coreSrst}, {31'd0, ~done});
      chk({tag, "_ready_idle"}, {31'd0, o_byteReady}, 32'd0);
      repeat (3) @(posedge i_clk);
      #1;
      chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   logic [159:0] prog;
   int           prog_n;
   logic [31:0]  sum;
   logic [31:0]  w;

   initial begin
`ifdef CHECKSUM_EN
      prog   = {96'h02000000_13051000_93052000, 32'hA60A3000};
      prog_n = 16;
      vecs[0] = mk("two_words", prog, prog_n, 2, 32'h0, 32'h00100513, 32'h4, 32'h00200593, 1'b1, 1'b0);
      vecs[1] = mk("zero_hdr", 160'h00000000, 4, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      vecs[2] = mk("too_many", 160'h01010000, 4, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      vecs[3] = mk("one_word", 160'h01000000_EFBEADDE_EFBEADDE, 12, 1, 32'h0, 32'hDEADBEEF, 0, 0, 1'b1, 1'b0);
      vecs[4] = mk("cks_ok", 160'h02000000_01000000_FFFFFFFF_00000000, 16, 2,
                   32'h0, 32'h00000001, 32'h4, 32'hFFFFFFFF, 1'b1, 1'b0);
      vecs[5] = mk("cks_bad", 160'h02000000_01000000_FFFFFFFF_01000000, 16, 2,
                   32'h0, 32'h00000001, 32'h4, 32'hFFFFFFFF, 1'b0, 1'b1);
      nv = 6;
`else
      prog   = 160'h02000000_13051000_93052000;
      prog_n = 12;
      vecs[0] = mk("two_words", prog, prog_n, 2, 32'h0, 32'h00100513, 32'h4, 32'h00200593, 1'b1, 1'b0);
      vecs[1] = mk("zero_hdr", 160'h00000000, 4, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      vecs[2] = mk("too_many", 160'h01010000, 4, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      vecs[3] = mk("one_word", 160'h01000000_EFBEADDE, 8, 1, 32'h0, 32'hDEADBEEF, 0, 0, 1'b1, 1'b0);
      nv = 4;
`endif

      // Reset values, and ready must wait for an edge after release.
      repeat (3) @(posedge i_clk);
      #1;
      check_reset_outputs("reset");
      #2 i_arstn = 1'b1;
      #1;
      chk("ready_before_edge", {31'd0, o_byteReady}, 32'd0);
      @(posedge i_clk);
      #1;
      chk("ready_after_edge", {31'd0, o_byteReady}, 32'd1);

      for (int v = 0; v < nv; v++) begin
         pulse_reload(1'b0);
         if (vecs[v].nw > 0) exp_q.push_back('{a: vecs[v].a0, d: vecs[v].d0});
         if (vecs[v].nw > 1) exp_q.push_back('{a: vecs[v].a1, d: vecs[v].d1});
         send_stream(vecs[v].s, vecs[v].n, vecs[v].n);
         $display("vector %s: done=%0b error=%0b", vecs[v].name, o_loadDone, o_error);
         check_end(vecs[v].name, vecs[v].done, vecs[v].err);
         if (vecs[v].nw > 0) begin
            chk({vecs[v].name, "_hold_addr"}, o_imemWriteAddress, (vecs[v].nw > 1) ? vecs[v].a1 : vecs[v].a0);
            chk({vecs[v].name, "_hold_data"}, o_imemWriteData, (vecs[v].nw > 1) ? vecs[v].d1 : vecs[v].d0);
         end
      end

      // Reload after the 6th byte, with a byte presented alongside the reload.
      pulse_reload(1'b0);
      send_stream(prog, prog_n, 6);
      pulse_reload(1'b1);
      exp_q.push_back('{a: 32'h0, d: 32'h00100513});
      exp_q.push_back('{a: 32'h4, d: 32'h00200593});
      send_stream(prog, prog_n, prog_n);
      $display("reload_restart: done=%0b", o_loadDone);
      check_end("reload_restart", 1'b1, 1'b0);

      // Largest legal load.
      pulse_reload(1'b0);
      send_word(32'd256);
      sum = 32'd0;
      for (int i = 0; i < 256; i++) begin
         w = 32'hA5000000 ^ (32'(i) * 32'h00010203);
         exp_q.push_back('{a: 32'(i) * 32'd4, d: w});
         sum = sum + w;
         send_word(w);
      end
`ifdef CHECKSUM_EN
      send_word(sum);
`endif
      $display("max_words: done=%0b", o_loadDone);
      check_end("max_words", 1'b1, 1'b0);

      // Random valid gaps, then reset mid-word.
      gaps = 1'b1;
      pulse_reload(1'b0);
      exp_q.push_back('{a: 32'h0, d: 32'h00100513});
      send_stream(prog, prog_n, 10);
      #3 i_arstn = 1'b0;
      #1;
      check_reset_outputs("midword_reset");
      repeat (3) @(posedge i_clk);
      #1;
      chk("midword_writes_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check_reset_outputs("held_reset");
      i_arstn = 1'b1;
      @(posedge i_clk);
      #1;
      exp_q.push_back('{a: 32'h0, d: 32'h00100513});
      exp_q.push_back('{a: 32'h4, d: 32'h00200593});
      send_stream(prog, prog_n, prog_n);
      $display("gapped_after_reset: done=%0b", o_loadDone);
      check_end("gapped_after_reset", 1'b1, 1'b0);
      gaps = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning the instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDRESS, default 32'h0, meaning the byte address of the first loaded word.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_arstn, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port i_byteValid, input, 1, meaning a boot stream byte is present.
REQ-006 SHALL have port i_byte, input, 8, the boot stream byte.
REQ-007 SHALL have port o_byteReady, output, 1, meaning the loader accepts a byte this cycle.
REQ-008 SHALL have port i_reload, input, 1, a single-cycle pulse that restarts loading.
REQ-009 SHALL have port o_imemWriteEn, output, 1, the instruction memory write strobe.
REQ-010 SHALL have port o_imemWriteAddress, output, 32, the instruction memory byte address.
REQ-011 SHALL have port o_imemWriteData, output, 32, the instruction word.
REQ-012 SHALL have port o_coreSrst, output, 1, the synchronous reset that holds the core (pc) in reset.
REQ-013 SHALL have port o_loadDone, output, 1, meaning the program was loaded successfully.
REQ-014 SHALL have port o_error, output, 1, meaning the load failed.

Function
REQ-015 SHALL transfer a byte only on a cycle where i_byteValid && o_byteReady.
REQ-016 SHALL drive o_byteReady=1 only in states HEADER, PAYLOAD and CHECK, and only while i_reload=0.
REQ-017 SHALL assemble every 32-bit field little-endian: the first byte goes to bits [7:0] and the fourth byte to bits [31:24].
REQ-018 SHALL, in HEADER, collect 4 bytes into wordCount.
REQ-019 SHALL, after the 4th HEADER byte, go to DONE if wordCount==0, go to ERROR if wordCount>MAX_WORDS, and otherwise go to PAYLOAD.
REQ-020 SHALL, in PAYLOAD, assemble each group of 4 bytes into a word and pulse o_imemWriteEn for exactly one cycle, on the cycle after the 4th byte is accepted.
REQ-021 SHALL drive o_imemWriteAddress = BASE_ADDRESS + 4*index during the write pulse, where index counts 0..wordCount-1 and wraps modulo 2^32.
REQ-022 SHALL sustain one byte per cycle, with no stall during or around write pulses.
REQ-023 SHALL, after word wordCount-1 is accepted, go to CHECK if CHECKSUM_EN is defined, and otherwise go to DONE.
REQ-024 SHALL, in DONE, drive o_coreSrst=0, o_loadDone=1 and o_byteReady=0, and hold these until i_reload or reset.
REQ-025 SHALL, in ERROR, drive o_coreSrst=1, o_error=1 and o_byteReady=0, and hold these until i_reload or reset.
REQ-026 SHALL hold o_coreSrst=1 in HEADER, PAYLOAD and CHECK.
REQ-027 SHALL, on i_reload in any state, enter HEADER on the next cycle and clear byte count, word index and checksum.
REQ-028 SHALL drop a byte presented in the same cycle as i_reload, and SHALL assert o_coreSrst=1 from the next cycle.
REQ-029 SHALL suppress a write pulse pending when i_reload is asserted.
REQ-030 SHALL hold o_imemWriteAddress and o_imemWriteData at their last values while o_imemWriteEn=0.

Reset
REQ-031 SHALL, while i_arstn=0, asynchronously force state=HEADER, all counters=0, o_byteReady=0, o_imemWriteEn=0, o_imemWriteAddress=0, o_imemWriteData=0, o_coreSrst=1, o_loadDone=0 and o_error=0.
REQ-032 SHALL, on reset assertion mid-load, discard the partial word and perform no write.
REQ-033 SHALL raise o_byteReady no earlier than the first clock edge after i_arstn deasserts.

Configuration
REQ-034 SHALL, with CHECKSUM_EN defined, accumulate sum = sum + word (mod 2^32) over all payload words and enter CHECK after the last word.
REQ-035 SHALL, in CHECK, collect 4 bytes and go to DONE if they equal sum, and otherwise go to ERROR.
REQ-036 SHALL, without CHECKSUM_EN defined, omit the CHECK state and accumulator, so the stream ends after the last payload word.

Verification
REQ-037 SHALL cover: bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 streamed back-to-back -> writes (0x0, 0x00100513) then (0x4, 0x00200593), then o_loadDone=1 and o_coreSrst=0.
REQ-038 SHALL cover: header 00 00 00 00 -> no write, and DONE on the cycle after the 4th byte.
REQ-039 SHALL cover: header 01 01 00 00 (257) with MAX_WORDS=256 -> ERROR, o_error=1, o_coreSrst=1, and no write.
REQ-040 SHALL cover, with CHECKSUM_EN defined: payload 0x00000001 and 0xFFFFFFFF with checksum 00 00 00 00 -> DONE; the same payload with checksum 01 00 00 00 -> ERROR.
REQ-041 SHALL cover: i_reload after the 6th byte of a 2-word load, then a full restart stream -> only the restarted words are written, and the first is at address 0x0.
REQ-042 SHALL cover: i_byteValid toggling randomly and i_arstn pulsed low mid-word -> no spurious write, and all outputs at their reset values.
